// File: rtl/int_pkg.sv
// Shared types and register-block offsets for the interrupt arbiter.
`default_nettype none

package int_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } int_state_t;

  localparam logic [1:0] INT_MASK_OFS = 2'd0;
  localparam logic [1:0] INT_PEND_OFS = 2'd1;
  localparam logic [1:0] INT_EDGE_OFS = 2'd2;
  localparam logic [1:0] INT_STAT_OFS = 2'd3;

endpackage

`default_nettype wire

// File: rtl/int_prio_select.sv
// Combinational winner select over eligible sources: fixed (lowest index) or
// round-robin (first set bit after last_id, wrapping modulo NUM_SRC).
`default_nettype none

module int_prio_select #(
  parameter int NUM_SRC     = 4,
  parameter int ROUND_ROBIN = 0
) (
  input  logic [NUM_SRC-1:0] elig,
  input  logic [2:0]         last_id,
  output logic               valid,
  output logic [2:0]         id
);

  logic [3:0]         start;
  logic [3:0]         base;
  logic [NUM_SRC-1:0] rot;
  logic [NUM_SRC-1:0] scan;
  logic [2:0]         pos;
  logic [3:0]         sum;

  always_comb begin
    start = {1'b0, last_id} + 4'd1;
    if (start >= 4'(NUM_SRC)) start = 4'd0;
    // Rotate so that the scan always begins at bit 0; pos is then an offset from base.
    rot   = NUM_SRC'({elig, elig} >> start);
    scan  = (ROUND_ROBIN != 0) ? rot : elig;
    base  = (ROUND_ROBIN != 0) ? start : 4'd0;

    pos   = 3'd0;
    valid = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (scan[i]) begin
        pos   = 3'(i);
        valid = 1'b1;
      end
    end

    sum = base + {1'b0, pos};
    if (sum >= 4'(NUM_SRC)) sum = sum - 4'(NUM_SRC);
    id = sum[2:0];
  end

endmodule

`default_nettype wire

// File: rtl/int_arbiter.sv
// Multi-source interrupt controller: pending/mask/edge registers on the core's
// port bus, one request to the pipeline, entry/exit sequencing via dec_int/reti_done.
`default_nettype none

module int_arbiter
  import int_pkg::*;
#(
  parameter int          NUM_SRC     = 4,
  parameter logic [7:0]  BASE_PORT   = 8'h20,
  parameter int          ROUND_ROBIN = 0,
  parameter logic [7:0]  VEC_BASE    = 8'hF0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] src,
  input  logic               int_flag,
  input  logic               dec_int,
  input  logic               reti_done,
  input  logic [7:0]         io_port_id,
  input  logic [7:0]         io_out_data,
  input  logic               io_wr_strb,
  output logic [7:0]         io_in_data,
  output logic               int_req,
  output logic [7:0]         int_vec,
  output logic               in_service
);

  int_state_t         state_q, state_d;
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] edge_q, edge_d;
  logic [2:0]         cur_id_q, cur_id_d;
  logic [2:0]         last_id_q, last_id_d;
  logic [7:0]         vec_q, vec_d;

  logic [NUM_SRC-1:0] elig;
  logic               sel_valid;
  logic [2:0]         sel_id;
  logic               any;
  logic               ack;
  logic [7:0]         ofs;
  logic               hit;
  logic               wr_mask, wr_pend, wr_edge;
  logic               set_b, clr_b;
  logic               unused_ok;

  assign elig = pending_q & mask_q;

  int_prio_select #(
    .NUM_SRC     (NUM_SRC),
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_sel (
    .elig    (elig),
    .last_id (last_id_q),
    .valid   (sel_valid),
    .id      (sel_id)
  );

  assign any = sel_valid & int_flag;
  assign ack = (state_q == REQ) & dec_int & any;

  // Register-block decode; the subtraction wraps so any BASE_PORT works.
  assign ofs       = io_port_id - BASE_PORT;
  assign hit       = (ofs[7:2] == 6'd0);
  assign wr_mask   = io_wr_strb & hit & (ofs[1:0] == INT_MASK_OFS);
  assign wr_pend   = io_wr_strb & hit & (ofs[1:0] == INT_PEND_OFS);
  assign wr_edge   = io_wr_strb & hit & (ofs[1:0] == INT_EDGE_OFS);
  assign unused_ok = ^io_out_data;

  always_comb begin
    mask_d    = wr_mask ? io_out_data[NUM_SRC-1:0] : mask_q;
    edge_d    = wr_edge ? io_out_data[NUM_SRC-1:0] : edge_q;
    pending_d = pending_q;
    set_b     = 1'b0;
    clr_b     = 1'b0;
    // A same-cycle set always beats ack or write-1-to-clear.
    for (int i = 0; i < NUM_SRC; i++) begin
      set_b        = edge_q[i] ? (src[i] & ~src_q[i]) : src[i];
      clr_b        = (ack && (sel_id == 3'(i))) || (wr_pend && io_out_data[i]);
      pending_d[i] = set_b | (pending_q[i] & ~clr_b);
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_id_d  = cur_id_q;
    last_id_d = last_id_q;
    vec_d     = vec_q;
    case (state_q)
      IDLE: begin
        if (any) state_d = REQ;
      end
      REQ: begin
        if (!any) begin
          state_d = IDLE;
        end else if (dec_int) begin
          state_d   = SERVICE;
          cur_id_d  = sel_id;
          last_id_d = sel_id;
          vec_d     = VEC_BASE + {5'd0, sel_id};
        end
      end
      SERVICE: begin
        if (reti_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      src_q     <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      edge_q    <= '0;
      cur_id_q  <= 3'd0;
      last_id_q <= 3'(NUM_SRC - 1);
      vec_q     <= VEC_BASE;
    end else begin
      state_q   <= state_d;
      src_q     <= src;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      edge_q    <= edge_d;
      cur_id_q  <= cur_id_d;
      last_id_q <= last_id_d;
      vec_q     <= vec_d;
    end
  end

  always_comb begin
    io_in_data = 8'h00;
    if (hit) begin
      case (ofs[1:0])
        INT_MASK_OFS: io_in_data = 8'(mask_q);
        INT_PEND_OFS: io_in_data = 8'(pending_q);
        INT_EDGE_OFS: io_in_data = 8'(edge_q);
        INT_STAT_OFS: io_in_data = {(state_q == SERVICE), 4'b0000, cur_id_q};
        default:      io_in_data = 8'h00;
      endcase
    end
  end

  assign int_req    = (state_q == REQ);
  assign in_service = (state_q == SERVICE);
  assign int_vec    = vec_q;

endmodule

`default_nettype wire

// File: tb/tb_int_arbiter.sv
// Scoreboarded bench: a fixed-priority and a round-robin instance; expected
// vectors are queued at dec_int and checked when in_service rises.
`default_nettype none
`timescale 1ns/1ps

module tb_int_arbiter;
  import int_pkg::*;

  localparam logic [7:0] BASE = 8'h20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       f_rst_n, f_flag, f_dec, f_reti, f_wr, f_req, f_isv;
  logic [3:0] f_src;
  logic [7:0] f_pid, f_wd, f_rd, f_vec;
  logic       r_rst_n, r_flag, r_dec, r_reti, r_wr, r_req, r_isv;
  logic [3:0] r_src;
  logic [7:0] r_pid, r_wd, r_rd, r_vec;

  int checks = 0;
  int errors = 0;
  logic [7:0] f_expq[$];
  logic [7:0] r_expq[$];
  logic f_isv_prev = 1'b0;
  logic r_isv_prev = 1'b0;

  int_arbiter #(.NUM_SRC(4), .BASE_PORT(BASE), .ROUND_ROBIN(0), .VEC_BASE(8'hF0)) u_fix (
    .clk(clk), .reset_n(f_rst_n), .src(f_src), .int_flag(f_flag), .dec_int(f_dec),
    .reti_done(f_reti), .io_port_id(f_pid), .io_out_data(f_wd), .io_wr_strb(f_wr),
    .io_in_data(f_rd), .int_req(f_req), .int_vec(f_vec), .in_service(f_isv)
  );

  int_arbiter #(.NUM_SRC(4), .BASE_PORT(BASE), .ROUND_ROBIN(1), .VEC_BASE(8'hF0)) u_rr (
    .clk(clk), .reset_n(r_rst_n), .src(r_src), .int_flag(r_flag), .dec_int(r_dec),
    .reti_done(r_reti), .io_port_id(r_pid), .io_out_data(r_wd), .io_wr_strb(r_wr),
    .io_in_data(r_rd), .int_req(r_req), .int_vec(r_vec), .in_service(r_isv)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input bit sel, input logic [1:0] o, input logic [7:0] d);
    if (sel) begin r_pid = BASE + 8'(o); r_wd = d; r_wr = 1'b1; end
    else     begin f_pid = BASE + 8'(o); f_wd = d; f_wr = 1'b1; end
    tick();
    f_wr = 1'b0;
    r_wr = 1'b0;
  endtask

  task automatic rd_chk(input bit sel, input logic [7:0] port, input logic [7:0] exp,
                        input string name);
    if (sel) r_pid = port; else f_pid = port;
    #1;
    chk(name, sel ? r_rd : f_rd, exp);
  endtask

  task automatic pulse_src(input bit sel, input logic [3:0] v);
    if (sel) r_src = v; else f_src = v;
    tick();
    f_src = 4'd0;
    r_src = 4'd0;
  endtask

  task automatic wait_req(input bit sel, input string name);
    bit seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if ((sel ? r_req : f_req) === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    if (!seen) chk(name, 8'h00, 8'h01);
  endtask

  task automatic service(input bit sel, input logic [7:0] exp);
    wait_req(sel, "req_timeout");
    if (sel) begin r_expq.push_back(exp); r_dec = 1'b1; end
    else     begin f_expq.push_back(exp); f_dec = 1'b1; end
    tick();
    f_dec = 1'b0; r_dec = 1'b0;
    tick();
    if (sel) r_reti = 1'b1; else f_reti = 1'b1;
    tick();
    f_reti = 1'b0; r_reti = 1'b0;
  endtask

  // Monitor: each entry into service must present the next queued vector.
  always @(posedge clk) begin
    #1;
    if (f_isv && !f_isv_prev) begin
      if (f_expq.size() == 0) chk("f_unexpected_service", f_vec, 8'h00);
      else chk("f_vec", f_vec, f_expq.pop_front());
    end
    if (r_isv && !r_isv_prev) begin
      if (r_expq.size() == 0) chk("r_unexpected_service", r_vec, 8'h00);
      else chk("r_vec", r_vec, r_expq.pop_front());
    end
    f_isv_prev = f_isv;
    r_isv_prev = r_isv;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    f_rst_n = 0; f_flag = 0; f_dec = 0; f_reti = 0; f_wr = 0; f_src = 0; f_pid = 0; f_wd = 0;
    r_rst_n = 0; r_flag = 0; r_dec = 0; r_reti = 0; r_wr = 0; r_src = 0; r_pid = 0; r_wd = 0;
    repeat (3) tick();
    f_rst_n = 1; r_rst_n = 1;

    // Reset state and register map
    chk("rst_req", 8'(f_req), 8'h00);
    chk("rst_isv", 8'(f_isv), 8'h00);
    chk("rst_vec", f_vec, 8'hF0);
    rd_chk(0, BASE + 8'(INT_MASK_OFS), 8'h00, "rst_mask");
    rd_chk(0, BASE + 8'(INT_STAT_OFS), 8'h00, "rst_stat");
    rd_chk(0, 8'h30, 8'h00, "unmapped");
    wr(0, INT_EDGE_OFS, 8'hFF);
    rd_chk(0, BASE + 8'(INT_EDGE_OFS), 8'h0F, "edge_rb");
    f_dec = 1; tick(); f_dec = 0;
    chk("dec_idle_ignored", 8'(f_isv), 8'h00);

    // Fixed priority: two edges, lowest index first
    wr(0, INT_MASK_OFS, 8'h0F);
    f_flag = 1;
    f_src = 4'b0110; tick(); f_src = 0;
    chk("req_lat1", 8'(f_req), 8'h00);
    rd_chk(0, BASE + 8'(INT_PEND_OFS), 8'h06, "pend_06");
    tick();
    chk("req_lat2", 8'(f_req), 8'h01);
    f_expq.push_back(8'hF1); f_dec = 1; tick(); f_dec = 0;
    chk("req_fall", 8'(f_req), 8'h00);
    chk("isv_on", 8'(f_isv), 8'h01);
    rd_chk(0, BASE + 8'(INT_PEND_OFS), 8'h04, "pend_04");
    rd_chk(0, BASE + 8'(INT_STAT_OFS), 8'h81, "stat_81");
    f_reti = 1; tick(); f_reti = 0;
    chk("isv_off", 8'(f_isv), 8'h00);
    service(0, 8'hF2);
    rd_chk(0, BASE + 8'(INT_PEND_OFS), 8'h00, "pend_empty");

    // Masking and global enable
    wr(0, INT_MASK_OFS, 8'h00);
    pulse_src(0, 4'b0001);
    rd_chk(0, BASE + 8'(INT_PEND_OFS), 8'h01, "masked_pend");
    tick();
    chk("masked_noreq", 8'(f_req), 8'h00);
    wr(0, INT_MASK_OFS, 8'h01);
    tick();
    chk("unmask_req", 8'(f_req), 8'h01);
    f_flag = 0; tick();
    chk("flag_drop_req", 8'(f_req), 8'h00);
    chk("flag_drop_vec", f_vec, 8'hF2);
    rd_chk(0, BASE + 8'(INT_STAT_OFS), 8'h02, "flag_drop_stat");
    f_flag = 1;
    service(0, 8'hF0);

    // Ack versus same-cycle edge on the winner
    wr(0, INT_MASK_OFS, 8'h0F);
    pulse_src(0, 4'b0100);
    tick();
    chk("coll_req", 8'(f_req), 8'h01);
    f_expq.push_back(8'hF2); f_dec = 1; f_src = 4'b0100; tick(); f_dec = 0; f_src = 0;
    chk("coll_isv", 8'(f_isv), 8'h01);
    rd_chk(0, BASE + 8'(INT_PEND_OFS), 8'h04, "ack_vs_set");
    f_reti = 1; tick(); f_reti = 0;
    service(0, 8'hF2);

    // W1C versus same-cycle edge, then plain W1C
    wr(0, INT_MASK_OFS, 8'h00);
    pulse_src(0, 4'b0100);
    rd_chk(0, BASE + 8'(INT_PEND_OFS), 8'h04, "pre_w1c");
    tick();
    f_pid = BASE + 8'(INT_PEND_OFS); f_wd = 8'h04; f_wr = 1; f_src = 4'b0100;
    tick(); f_wr = 0; f_src = 0;
    rd_chk(0, BASE + 8'(INT_PEND_OFS), 8'h04, "w1c_vs_set");
    wr(0, INT_PEND_OFS, 8'h04);
    rd_chk(0, BASE + 8'(INT_PEND_OFS), 8'h00, "w1c_clear");

    // Level mode: held source survives W1C
    wr(0, INT_EDGE_OFS, 8'h00);
    f_src = 4'b0010; tick(); tick();
    rd_chk(0, BASE + 8'(INT_PEND_OFS), 8'h02, "level_pend");
    wr(0, INT_PEND_OFS, 8'h02);
    rd_chk(0, BASE + 8'(INT_PEND_OFS), 8'h02, "level_hold");
    f_src = 0;
    wr(0, INT_PEND_OFS, 8'h02);
    rd_chk(0, BASE + 8'(INT_PEND_OFS), 8'h00, "level_clear");
    wr(0, INT_EDGE_OFS, 8'h0F);

    // Service id 3, then asynchronous reset mid-service
    wr(0, INT_MASK_OFS, 8'h0F);
    pulse_src(0, 4'b1000);
    wait_req(0, "req3_timeout");
    f_expq.push_back(8'hF3); f_dec = 1; tick(); f_dec = 0;
    rd_chk(0, BASE + 8'(INT_STAT_OFS), 8'h83, "stat_83");
    tick();
    pulse_src(0, 4'b1000);
    rd_chk(0, BASE + 8'(INT_PEND_OFS), 8'h08, "pend_in_service");
    #2 f_rst_n = 0;
    #1;
    chk("arst_req", 8'(f_req), 8'h00);
    chk("arst_isv", 8'(f_isv), 8'h00);
    chk("arst_vec", f_vec, 8'hF0);
    rd_chk(0, BASE + 8'(INT_MASK_OFS), 8'h00, "arst_mask");
    rd_chk(0, BASE + 8'(INT_PEND_OFS), 8'h00, "arst_pend");
    rd_chk(0, BASE + 8'(INT_EDGE_OFS), 8'h00, "arst_edge");
    rd_chk(0, BASE + 8'(INT_STAT_OFS), 8'h00, "arst_stat");
    tick(); tick();
    f_rst_n = 1;
    tick();
    chk("post_rst_req", 8'(f_req), 8'h00);

    // Round-robin: make last_id = 1, then all four pending
    wr(1, INT_EDGE_OFS, 8'h0F);
    wr(1, INT_MASK_OFS, 8'h0F);
    r_flag = 1;
    pulse_src(1, 4'b0010);
    service(1, 8'hF1);
    pulse_src(1, 4'b1111);
    service(1, 8'hF2);
    service(1, 8'hF3);
    service(1, 8'hF0);
    service(1, 8'hF1);
    rd_chk(1, BASE + 8'(INT_PEND_OFS), 8'h00, "rr_pend_empty");

    repeat (3) tick();
    chk("f_queue_drained", 8'(f_expq.size()), 8'h00);
    chk("r_queue_drained", 8'(r_expq.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/int_arbiter.md
Name: int_arbiter

Overview:
- Multi-source interrupt controller in front of pipeline_control.
- Collects up to 8 external interrupt sources and holds them in a pending register; applies a software mask and selects one winner by fixed or round-robin priority.
- Raises a single interrupt request to the pipeline, which the core takes as its `interrupt` input.
- Sequences entry and exit of the service routine using the pipeline's dec_int acknowledge and a RETI-completion pulse.
- Its mask, pending, edge-mode and current-id registers are reached from the core's OUT/IN port bus.

Parameters:
- NUM_SRC, 4, number of interrupt sources (1..8).
- BASE_PORT, 8'h20, first I/O port ID of the register block (occupies BASE_PORT..BASE_PORT+3).
- ROUND_ROBIN, 0, 0 = fixed priority (index 0 highest), 1 = round-robin starting after the last-serviced id.
- VEC_BASE, 8'hF0, vector base; int_vec = VEC_BASE + winning id.

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- src, input, NUM_SRC, interrupt sources, synchronous to clk.
- int_flag, input, 1, core global interrupt enable (SEI/CLI state).
- dec_int, input, 1, pipeline acknowledge: interrupt accepted this cycle.
- reti_done, input, 1, one-cycle pulse when the RETI instruction retires.
- io_port_id, input, 8, port address from the core.
- io_out_data, input, 8, write data from the core.
- io_wr_strb, input, 1, port write strobe.
- io_in_data, output, 8, read data (combinational on io_port_id).
- int_req, output, 1, interrupt request to pipeline_control.
- int_vec, output, 8, vector of the accepted interrupt.
- in_service, output, 1, high while the service routine is active.

Behaviour:
- Reset: asynchronous on reset_n low; all registers clear.
  - state = IDLE; pending = 0; mask = 0; edge_mode = 0 (level); src_q = 0; cur_id = 0; last_id = NUM_SRC-1.
  - Outputs: int_req = 0, int_vec = VEC_BASE, in_service = 0.
  - Reset during REQ or SERVICE abandons the operation; no residual request.
- Source capture:
  - Edge mode (edge_mode[i] = 1): a rising edge on src[i] (src[i] & ~src_q[i]) sets pending[i].
  - Level mode: pending[i] follows src[i] while src[i] is high; a level bit is cleared only by ack or W1C.
  - Set wins over any same-cycle clear (ack or W1C).
  - Latency: src sampled high at edge k → pending[i] = 1 after edge k.
- Eligibility: elig = pending & mask; any = |elig & int_flag.
- State machine, one-hot-free enum {IDLE, REQ, SERVICE}:
  - IDLE → REQ when any. int_req is registered: it equals (state == REQ) and is first high one cycle after pending.
  - REQ → IDLE if !any (mask cleared, W1C, or int_flag dropped) before dec_int; no vector is latched.
  - REQ with dec_int: latch winner into cur_id and last_id; int_vec = VEC_BASE + winner; clear pending[winner]; go to SERVICE. int_req falls on the same edge.
  - SERVICE: int_req = 0 and in_service = 1; no nesting. New sources continue to accumulate in pending.
  - SERVICE → IDLE on reti_done. If sources are still eligible, REQ is re-entered on the next edge.
  - dec_int in IDLE or SERVICE is ignored; reti_done outside SERVICE is ignored.
- Winner selection: combinational over elig.
  - Fixed priority: lowest index wins.
  - Round-robin: first set bit scanning from last_id+1 modulo NUM_SRC, with wrap-around.
  - The winner is recomputed each cycle; the value at the dec_int cycle is the one latched.
- Register map (writes take effect on the edge with io_wr_strb and a matching io_port_id; bits ≥ NUM_SRC read as 0 and ignore writes):
  - BASE+0 mask: R/W.
  - BASE+1 pending: read; write 1 to clear.
  - BASE+2 edge_mode: R/W. Changing a bit's mode does not alter its pending value.
  - BASE+3: {in_service, 4'b0, cur_id[2:0]}, read-only.
  - Unmapped port IDs: io_in_data = 8'h00.

Decomposition:
- Shared package int_pkg holds:
  - typedef enum IntState {IDLE, REQ, SERVICE};
  - register offset constants INT_MASK_OFS = 0, INT_PEND_OFS = 1, INT_EDGE_OFS = 2, INT_STAT_OFS = 3.
- One sub-module, int_prio_select: combinational select of elig and last_id, producing a valid flag and a 3-bit id. It implements both the fixed and round-robin modes under ROUND_ROBIN.

Test Plan:
- Fixed priority: NUM_SRC = 4, mask = 4'hF, int_flag = 1, edge mode, pulse src = 4'b0110 → int_req after 2 cycles; dec_int → int_vec = F1, pending = 4'b0100; reti_done → int_req again, then int_vec = F2.
- Round-robin: ROUND_ROBIN = 1, last_id = 1, all four pending → serviced order 2, 3, 0, 1 (vectors F2, F3, F0, F1).
- Masking and enable: mask = 0, src[0] rises → pending = 1, int_req stays 0; write mask = 1 → int_req rises; int_flag = 0 while in REQ → return to IDLE with int_req = 0 and no vector latched.
- Collisions: src[2] edge in the same cycle as dec_int selecting id 2 → pending[2] remains 1. W1C of pending = 4'h4 in the same cycle as a src[2] edge → pending[2] = 1.
- Reset mid-service: in SERVICE with pending = 4'b1000, drop reset_n asynchronously mid-cycle → immediately int_req = 0, in_service = 0, int_vec = F0, and all register reads return 0.
- Register readback: write edge_mode = 8'hFF → read 8'h0F (NUM_SRC = 4); read BASE+3 in SERVICE with id 3 → 8'h83; read port 8'h30 → 8'h00.
